buyruk_onbellegi: RTL and testbench
===================================

Name: buyruk_onbellegi

Overview:
Instruction-cache responder on the memory side of the fetch-stage interface: it accepts fetch requests (istek + ps) and returns the instruction word with a one-cycle gecerli pulse. It is direct-mapped with multi-word lines. Misses are refilled word by word from main memory over a request/valid handshake. It sits between the fetch stage and the main-memory arbiter.

Parameters:
SATIR_SAYISI, 64, number of cache lines (power of 2)
KELIME_SAYISI, 4, 32-bit words per line (power of 2, >=2)
ADRES_GENISLIGI, 32, byte-address width

Ports:
clk_i  input  1  clock
rst_i  input  1  synchronous reset, active-low
getir_istek_i  input  1  fetch request, level-held by fetch stage
getir_ps_i  input  ADRES_GENISLIGI  requested byte address; bits [1:0] ignored
getir_gecerli_o  output  1  one-cycle pulse: getir_deger_o valid for the accepted ps
getir_deger_o  output  32  instruction word
anabellek_istek_o  output  1  refill word request
anabellek_adres_o  output  ADRES_GENISLIGI  refill word byte address
anabellek_gecerli_i  input  1  refill word valid
anabellek_deger_i  input  32  refill word data
isabet_sayaci_o  output  32  hit count (optional feature)
iskalama_sayaci_o  output  32  miss count (optional feature)

Behaviour:
- Address split: byte offset [1:0], word offset log2(KELIME_SAYISI), index log2(SATIR_SAYISI), tag = remaining upper bits.
- Storage: a valid bit per line (flops), a tag array, and a data array with a registered read.
- Reset (rst_i==0 at clk edge):
  - all valid bits cleared; state BOSTA.
  - getir_gecerli_o=0, getir_deger_o=0, anabellek_istek_o=0, anabellek_adres_o=0, beat counter=0.
  - A reset during DOLDUR aborts the refill. The line stays invalid and anabellek_istek_o is low after that edge.
- State BOSTA, with getir_istek_i=1 at edge N:
  - ps is captured.
  - Hit (valid && tag match): getir_gecerli_o=1 and getir_deger_o=word at N+1. Stay BOSTA, so back-to-back hits give one word per cycle.
  - Miss: go to DOLDUR, beat=0; getir_gecerli_o stays 0.
- State DOLDUR:
  - anabellek_istek_o=1, anabellek_adres_o = line base + beat*4, both held stable until anabellek_gecerli_i=1.
  - On each valid beat: write anabellek_deger_i into the data array and a line buffer, then beat++.
  - After beat KELIME_SAYISI-1 is accepted: set tag and valid, drop anabellek_istek_o at the next edge, go to YANIT.
  - Refill order is always word 0 upward, with no critical-word-first.
- State YANIT (one cycle): if getir_istek_i=1 and getir_ps_i[ADRES_GENISLIGI-1:2] equals the captured address:
  - pulse getir_gecerli_o with the captured word from the line buffer.
  - Otherwise (fetch redirected or dropped request) produce no pulse.
  - In both cases go to BOSTA, where any current request is looked up normally.
- A redirect during DOLDUR never aborts the refill; the completed line is still installed.
- anabellek_gecerli_i while not in DOLDUR is ignored.
- getir_gecerli_o is never high for two cycles from one acceptance. getir_deger_o holds its last value when gecerli is low.
- getir_istek_i=0 in BOSTA means no state change.

Optional Feature:
- Macro ONBELLEK_SAYAC_EN.
- Defined:
  - isabet_sayaci_o increments once per BOSTA hit.
  - iskalama_sayaci_o increments once per DOLDUR entry.
  - Both are cleared by reset and wrap modulo 2^32.
- Undefined: both outputs are tied to 0 and no counter flops exist.

Decomposition:
- Package buyruk_onbellegi_pkg holds:
  - state encoding BOSTA/DOLDUR/YANIT.
  - localparam functions for offset, index and tag widths.
- Sub-module onbellek_veri_bellegi: the data RAM, one write port, one registered read port, SATIR_SAYISI*KELIME_SAYISI x 32.

Test Plan:
- Cold miss: reset; request ps=0 held.
  - anabellek_istek_o=1 at addresses 0,4,8,12 in turn; memory returns 10,20,30,40 with 1-cycle latency.
  - Then getir_gecerli_o pulses once with getir_deger_o=10.
- Hit streaming: after that line is filled, request ps=4,8,12 on consecutive cycles.
  - gecerli_o pulses on 3 consecutive cycles with deger_o=20,30,40.
- Redirect during refill: miss on ps=696; mid-refill, change ps to 0, which hits.
  - Refill completes and there is no pulse for 696.
  - Next cycle: pulse with deger_o=10.
  - Then a request to 696 hits.
- Stalled memory: hold anabellek_gecerli_i=0 for 5 cycles during beat 2.
  - anabellek_adres_o stays at base+8, and no gecerli_o pulse occurs.
- Reset mid-refill: assert rst_i=0 after beat 1.
  - anabellek_istek_o is 0 the next cycle.
  - A re-request of the same ps misses again.
- ONBELLEK_SAYAC_EN: 1 miss followed by 3 hits gives iskalama_sayaci_o=1 and isabet_sayaci_o=3.

Source files
------------

// File: rtl/buyruk_onbellegi_pkg.sv
// Shared types and geometry helpers for the instruction cache.
// Address split: tag | index | word offset | byte offset.
package buyruk_onbellegi_pkg;

  typedef enum logic [1:0] {
    BOSTA  = 2'd0,
    DOLDUR = 2'd1,
    YANIT  = 2'd2
  } durum_e;

  function automatic int ofset_gen(input int kelime);
    return $clog2(kelime);
  endfunction

  function automatic int indeks_gen(input int satir);
    return $clog2(satir);
  endfunction

  function automatic int etiket_gen(
    input int adres,
    input int satir,
    input int kelime
  );
    return adres - 2 - $clog2(kelime) - $clog2(satir);
  endfunction

endpackage

// File: rtl/onbellek_veri_bellegi.sv
// Cache data RAM: one write port, one registered read port.
// Contents are not reset; the valid bits guard every read.
module onbellek_veri_bellegi #(
  parameter int DERINLIK = 256,
  parameter int AG       = 8
) (
  input  logic          clk_i,
  input  logic          yaz_i,
  input  logic [AG-1:0] yaz_adres_i,
  input  logic [31:0]   yaz_veri_i,
  input  logic [AG-1:0] oku_adres_i,
  output logic [31:0]   oku_veri_o
);

  logic [31:0] bellek_q [DERINLIK];
  logic [31:0] oku_q;

  always_ff @(posedge clk_i) begin
    if (yaz_i) begin
      bellek_q[yaz_adres_i] <= yaz_veri_i;
    end
    oku_q <= bellek_q[oku_adres_i];
  end

  assign oku_veri_o = oku_q;

endmodule

// File: rtl/buyruk_onbellegi.sv
// Direct-mapped instruction cache with word-by-word line refill.
// Optional hit/miss counters are enabled by ONBELLEK_SAYAC_EN.
module buyruk_onbellegi
  import buyruk_onbellegi_pkg::*;
#(
  parameter int SATIR_SAYISI    = 64,
  parameter int KELIME_SAYISI   = 4,
  parameter int ADRES_GENISLIGI = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       getir_istek_i,
  input  logic [ADRES_GENISLIGI-1:0] getir_ps_i,
  output logic                       getir_gecerli_o,
  output logic [31:0]                getir_deger_o,
  output logic                       anabellek_istek_o,
  output logic [ADRES_GENISLIGI-1:0] anabellek_adres_o,
  input  logic                       anabellek_gecerli_i,
  input  logic [31:0]                anabellek_deger_i,
  output logic [31:0]                isabet_sayaci_o,
  output logic [31:0]                iskalama_sayaci_o
);

  localparam int OW = ofset_gen(KELIME_SAYISI);
  localparam int IW = indeks_gen(SATIR_SAYISI);
  localparam int TW = etiket_gen(ADRES_GENISLIGI, SATIR_SAYISI,
                                 KELIME_SAYISI);
  localparam int WA = ADRES_GENISLIGI - 2;
  localparam int RW = IW + OW;
  localparam logic [OW-1:0] SON_BEAT = OW'(KELIME_SAYISI - 1);
  localparam logic [OW-1:0] BIR      = OW'(1);

  logic [OW-1:0] ps_ofs;
  logic [IW-1:0] ps_idx;
  logic [TW-1:0] ps_tag;
  logic [WA-1:0] ps_kelime;

  assign ps_ofs    = getir_ps_i[2 +: OW];
  assign ps_idx    = getir_ps_i[2+OW +: IW];
  assign ps_tag    = getir_ps_i[ADRES_GENISLIGI-1 -: TW];
  assign ps_kelime = getir_ps_i[ADRES_GENISLIGI-1:2];

  logic unused_bayt;
  assign unused_bayt = ^getir_ps_i[1:0];

  durum_e                     durum_q;
  logic [OW-1:0]              beat_q;
  logic [WA-1:0]              yakala_q;
  logic [SATIR_SAYISI-1:0]    vbit_q;
  logic [TW-1:0]              etiket_q [SATIR_SAYISI];
  logic [31:0]                tampon_q [KELIME_SAYISI];
  logic                       gecerli_q;
  logic                       sec_q;
  logic [31:0]                deger_q;
  logic                       istek_q;
  logic [ADRES_GENISLIGI-1:0] adres_q;

  logic [IW-1:0] c_idx;
  logic [OW-1:0] c_ofs;
  assign c_idx = yakala_q[OW +: IW];
  assign c_ofs = yakala_q[OW-1:0];

  logic isabet;
  logic kabul;
  logic yaz;
  logic son;
  assign isabet = vbit_q[ps_idx] && (etiket_q[ps_idx] == ps_tag);
  assign kabul  = (durum_q == BOSTA) && getir_istek_i;
  assign yaz    = (durum_q == DOLDUR) && anabellek_gecerli_i;
  assign son    = yaz && (beat_q == SON_BEAT);

  logic [RW-1:0] ram_yaz_adres;
  logic [RW-1:0] ram_oku_adres;
  logic [31:0]   ram_veri;
  assign ram_yaz_adres = {c_idx, beat_q};
  assign ram_oku_adres = {ps_idx, ps_ofs};

  onbellek_veri_bellegi #(
    .DERINLIK (SATIR_SAYISI * KELIME_SAYISI),
    .AG       (RW)
  ) u_veri (
    .clk_i       (clk_i),
    .yaz_i       (yaz),
    .yaz_adres_i (ram_yaz_adres),
    .yaz_veri_i  (anabellek_deger_i),
    .oku_adres_i (ram_oku_adres),
    .oku_veri_o  (ram_veri)
  );

  always_ff @(posedge clk_i) begin
    if (yaz) begin
      tampon_q[beat_q] <= anabellek_deger_i;
    end
    if (son) begin
      etiket_q[c_idx] <= yakala_q[WA-1 -: TW];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      durum_q   <= BOSTA;
      beat_q    <= '0;
      yakala_q  <= '0;
      vbit_q    <= '0;
      gecerli_q <= 1'b0;
      sec_q     <= 1'b0;
      deger_q   <= '0;
      istek_q   <= 1'b0;
      adres_q   <= '0;
    end else begin
      gecerli_q <= 1'b0;
      sec_q     <= 1'b0;
      // latch the RAM word so the output holds after the pulse
      if (sec_q) begin
        deger_q <= ram_veri;
      end
      unique case (durum_q)
        BOSTA: begin
          if (getir_istek_i) begin
            yakala_q <= ps_kelime;
            if (isabet) begin
              gecerli_q <= 1'b1;
              sec_q     <= 1'b1;
            end else begin
              durum_q        <= DOLDUR;
              beat_q         <= '0;
              istek_q        <= 1'b1;
              adres_q        <= {ps_kelime[WA-1:OW], {OW{1'b0}}, 2'b00};
              vbit_q[ps_idx] <= 1'b0;
            end
          end
        end
        DOLDUR: begin
          if (anabellek_gecerli_i) begin
            beat_q  <= beat_q + BIR;
            adres_q <= {yakala_q[WA-1:OW], beat_q + BIR, 2'b00};
            if (beat_q == SON_BEAT) begin
              istek_q       <= 1'b0;
              vbit_q[c_idx] <= 1'b1;
              durum_q       <= YANIT;
            end
          end
        end
        YANIT: begin
          durum_q <= BOSTA;
          if (getir_istek_i && (ps_kelime == yakala_q)) begin
            gecerli_q <= 1'b1;
            deger_q   <= tampon_q[c_ofs];
          end
        end
        default: durum_q <= BOSTA;
      endcase
    end
  end

  assign getir_gecerli_o   = gecerli_q;
  assign getir_deger_o     = sec_q ? ram_veri : deger_q;
  assign anabellek_istek_o = istek_q;
  assign anabellek_adres_o = adres_q;

`ifdef ONBELLEK_SAYAC_EN
  logic [31:0] isabet_q;
  logic [31:0] iskalama_q;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      isabet_q   <= '0;
      iskalama_q <= '0;
    end else if (kabul) begin
      if (isabet) begin
        isabet_q <= isabet_q + 32'd1;
      end else begin
        iskalama_q <= iskalama_q + 32'd1;
      end
    end
  end

  assign isabet_sayaci_o   = isabet_q;
  assign iskalama_sayaci_o = iskalama_q;
`else
  logic unused_kabul;
  assign unused_kabul      = kabul;
  assign isabet_sayaci_o   = '0;
  assign iskalama_sayaci_o = '0;
`endif

endmodule

// File: tb/tb_buyruk_onbellegi.sv
// Bench for buyruk_onbellegi: directed scenarios then random fetches
// checked against a line-level cache model and a memory function.
module tb_buyruk_onbellegi;

  localparam int S = 64;
  localparam int K = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        istek;
  logic [31:0] ps;
  logic        gecerli;
  logic [31:0] deger;
  logic        a_istek;
  logic [31:0] a_adres;
  logic        a_gecerli;
  logic [31:0] a_deger;
  logic [31:0] is_say;
  logic [31:0] isk_say;

  always #5 clk = ~clk;

  buyruk_onbellegi dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .getir_istek_i       (istek),
    .getir_ps_i          (ps),
    .getir_gecerli_o     (gecerli),
    .getir_deger_o       (deger),
    .anabellek_istek_o   (a_istek),
    .anabellek_adres_o   (a_adres),
    .anabellek_gecerli_i (a_gecerli),
    .anabellek_deger_i   (a_deger),
    .isabet_sayaci_o     (is_say),
    .iskalama_sayaci_o   (isk_say)
  );

  int          checks = 0;
  int          errors = 0;
  bit          mvalid [S];
  int unsigned mtag   [S];
  int unsigned n_hit  = 0;
  int unsigned n_miss = 0;
  logic [31:0] adr_q [$];

  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a < 32'd16) return (a >> 2) * 32'd10 + 32'd10;
    return a * 32'h9E3779B1 + 32'h5A5A;
  endfunction

  function automatic bit mhit(input logic [31:0] a);
    int idx;
    idx = int'((a >> 4) & 32'd63);
    return mvalid[idx] && (mtag[idx] == 32'(a >> 10));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit stall);
    if (a_istek === 1'b1) begin
      if (stall) begin
        a_gecerli = 1'b0;
        a_deger   = $urandom;
      end else begin
        a_gecerli = 1'b1;
        a_deger   = memf(a_adres);
        adr_q.push_back(a_adres);
      end
    end else begin
      a_gecerli = 1'($urandom % 2);
      a_deger   = $urandom;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_say(input string tag);
`ifdef ONBELLEK_SAYAC_EN
    chk({tag, "_isabet"}, is_say, n_hit);
    chk({tag, "_iskalama"}, isk_say, n_miss);
`else
    chk({tag, "_isabet"}, is_say, 32'd0);
    chk({tag, "_iskalama"}, isk_say, 32'd0);
`endif
  endtask

  task automatic model_sifirla();
    for (int i = 0; i < S; i++) mvalid[i] = 1'b0;
    n_hit  = 0;
    n_miss = 0;
  endtask

  task automatic txn(input logic [31:0] a, input bit rstall,
                     input string tag);
    bit          h;
    bit          got;
    int          cyc;
    int          idx;
    logic [31:0] e;
    h   = mhit(a);
    e   = memf(a);
    idx = int'((a >> 4) & 32'd63);
    got = 1'b0;
    cyc = 0;
    adr_q.delete();
    ps    = a;
    istek = 1'b1;
    while (!got && cyc < 100) begin
      step(rstall ? ($urandom % 3 == 0) : 1'b0);
      cyc++;
      got = (gecerli === 1'b1);
    end
    istek = 1'b0;
    chk({tag, "_pulse"}, 32'(got), 32'd1);
    chk({tag, "_deger"}, deger, e);
    chk({tag, "_beats"}, 32'(adr_q.size()), h ? 32'd0 : 32'(K));
    foreach (adr_q[i])
      chk({tag, "_adres"}, adr_q[i], (a & ~32'hF) + 32'(i * 4));
    if (h) chk({tag, "_gecikme"}, 32'(cyc), 32'd1);
    else if (!rstall) chk({tag, "_gecikme"}, 32'(cyc), 32'(K + 2));
    if (h) n_hit++;
    else begin
      n_miss++;
      mvalid[idx] = 1'b1;
      mtag[idx]   = 32'(a >> 10);
    end
    step(1'b0);
    chk({tag, "_tek_pulse"}, 32'(gecerli), 32'd0);
    chk({tag, "_tut"}, deger, e);
  endtask

  initial begin
    int cyc;
    bit got;
    rst       = 1'b0;
    istek     = 1'b0;
    ps        = '0;
    a_gecerli = 1'b0;
    a_deger   = '0;
    model_sifirla();
    step(1'b0);
    step(1'b0);
    rst = 1'b1;

    chk("rst_gecerli", 32'(gecerli), 32'd0);
    chk("rst_deger", deger, 32'd0);
    chk("rst_aistek", 32'(a_istek), 32'd0);
    chk("rst_aadres", a_adres, 32'd0);
    chk_say("rst");

    txn(32'd0, 1'b0, "soguk");

    ps    = 32'd4;
    istek = 1'b1;
    step(1'b0);
    chk("akis4_g", 32'(gecerli), 32'd1);
    chk("akis4_d", deger, 32'd20);
    ps = 32'd8;
    step(1'b0);
    chk("akis8_g", 32'(gecerli), 32'd1);
    chk("akis8_d", deger, 32'd30);
    ps = 32'd12;
    step(1'b0);
    chk("akis12_g", 32'(gecerli), 32'd1);
    chk("akis12_d", deger, 32'd40);
    istek = 1'b0;
    step(1'b0);
    chk("akis_son", 32'(gecerli), 32'd0);
    n_hit += 3;

    // redirect to a hitting address while 696 refills
    ps    = 32'd696;
    istek = 1'b1;
    step(1'b0);
    chk("yon_aistek", 32'(a_istek), 32'd1);
    chk("yon_aadres", a_adres, 32'h2B0);
    step(1'b0);
    step(1'b0);
    ps  = 32'd0;
    cyc = 0;
    while (a_istek === 1'b1 && cyc < 20) begin
      step(1'b0);
      cyc++;
      chk("yon_dolum_pulse", 32'(gecerli), 32'd0);
    end
    step(1'b0);
    chk("yon_yanit_pulse", 32'(gecerli), 32'd0);
    step(1'b0);
    chk("yon_isabet_g", 32'(gecerli), 32'd1);
    chk("yon_isabet_d", deger, 32'd10);
    istek = 1'b0;
    n_miss++;
    n_hit++;
    mvalid[43] = 1'b1;
    mtag[43]   = 0;
    step(1'b0);
    chk("yon_son", 32'(gecerli), 32'd0);
    txn(32'd696, 1'b0, "yon_696");
    chk_say("yon");

    ps    = 32'h2040;
    istek = 1'b1;
    step(1'b0);
    step(1'b0);
    step(1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1);
      chk("dur_aadres", a_adres, 32'h2048);
      chk("dur_aistek", 32'(a_istek), 32'd1);
      chk("dur_pulse", 32'(gecerli), 32'd0);
    end
    got = 1'b0;
    cyc = 0;
    while (!got && cyc < 20) begin
      step(1'b0);
      cyc++;
      got = (gecerli === 1'b1);
    end
    istek = 1'b0;
    chk("dur_g", 32'(got), 32'd1);
    chk("dur_d", deger, memf(32'h2040));
    n_miss++;
    mvalid[4] = 1'b1;
    mtag[4]   = 8;
    step(1'b0);

    ps    = 32'h3050;
    istek = 1'b1;
    step(1'b0);
    step(1'b0);
    step(1'b0);
    rst = 1'b0;
    step(1'b0);
    chk("rstd_aistek", 32'(a_istek), 32'd0);
    chk("rstd_gecerli", 32'(gecerli), 32'd0);
    rst   = 1'b1;
    istek = 1'b0;
    model_sifirla();
    step(1'b0);
    chk("rstd_aistek2", 32'(a_istek), 32'd0);
    txn(32'h3050, 1'b0, "rstd_tekrar");
    txn(32'h3054, 1'b0, "say_h1");
    txn(32'h3058, 1'b0, "say_h2");
    txn(32'h305C, 1'b0, "say_h3");
    chk_say("say");

    for (int n = 0; n < 200; n++) begin
      logic [31:0] a;
      a = ((32'($urandom % 4)) << 10) | ((32'($urandom % 8)) << 4)
        | ((32'($urandom % 4)) << 2);
      txn(a, 1'b1, "rnd");
      if ($urandom % 4 == 0) step(1'b0);
    end
    chk_say("rnd");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
